i2c_reg_sequencer: RTL
======================

// Module: i2c_reg_sequencer
// PURPOSE
//  Sequences the byte-level I2C master through complete register transactions: write = START, dev+W,
//  reg, data, STOP; read = START, dev+W, reg, RESTART, dev+R, read byte with NACK, STOP.
//  Sits between a simple request/response client and the master's command/done interface.
//  Aborts on slave NACK or master timeout; always finishes with STOP.
// PARAMETERS
//  TIMEOUT_CYCLES  16'd4095  max clk cycles from command accept to done before abort (>=1)
// PORTS
//  clk            in   1   system clock; all logic on rising edge
//  reset_n        in   1   synchronous, active-low reset
//  req_valid      in   1   client request valid
//  req_ready      out  1   sequencer can accept a request (high only in IDLE)
//  req_rw         in   1   1 = read, 0 = write
//  req_dev_addr   in   7   7-bit slave address
//  req_reg_addr   in   8   register address
//  req_wdata      in   8   write data (ignored for reads)
//  resp_valid     out  1   one-cycle pulse: transaction finished
//  resp_rdata     out  8   read data, valid with resp_valid (0 for writes and aborts)
//  resp_nack      out  1   with resp_valid: slave NACKed an address/data byte
//  resp_timeout   out  1   with resp_valid: master did not report done in time
//  cmd_valid      out  1   command to master valid; held until cmd_ready
//  cmd_ready      in   1   master accepts command
//  cmd_op         out  3   0 START, 1 RESTART, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP
//  cmd_data       out  8   byte for WRITE; 0 otherwise
//  done_valid     in   1   one-cycle pulse: accepted command completed
//  done_ack       in   1   with done_valid after WRITE: 1 = slave ACKed
//  done_data      in   8   with done_valid after READ_*: received byte
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; cmd_valid=0; cmd_op=0; cmd_data=0; resp_*=0; timer=0.
//  Request accepted when req_valid & req_ready; fields latched that cycle; req_ready drops next cycle.
//  States: IDLE, START, DEV_W, REG, WDATA, RESTART, DEV_R, READ, STOP, RESP.
//  Each command state has two phases: ISSUE (cmd_valid=1 until cmd_ready) and WAIT (cmd_valid=0,
//   timer counts until done_valid). cmd_op/cmd_data stable while cmd_valid=1.
//  First cmd_valid appears the cycle after acceptance. done_valid is ignored in ISSUE phase and IDLE.
//  Transitions on done_valid: START->DEV_W; DEV_W(byte {dev,0})->REG; REG->WDATA (write) or
//   RESTART (read); WDATA->STOP; RESTART->DEV_R(byte {dev,1}); DEV_R->READ (READ_NACK, capture
//   done_data); READ->STOP; STOP->RESP.
//  NACK: done_ack=0 on DEV_W, REG, WDATA or DEV_R -> set nack flag, go to STOP.
//  Timeout: timer 16-bit, cleared on cmd accept, +1 per WAIT cycle; timer==TIMEOUT_CYCLES without
//   done -> set timeout flag, go to STOP. Timeout in STOP -> go to RESP directly. Timer saturates.
//  done_valid and timeout in the same cycle: done wins.
//  RESP: resp_valid=1 one cycle with flags and rdata (rdata forced 0 if any flag); then IDLE,
//   req_ready=1 the following cycle. Flags cleared on next accept.
//  Back-to-back: minimum one IDLE cycle between transactions.
//  Reset mid-transaction: returns to IDLE immediately, no STOP, no resp_valid.
// TESTING
//  Write dev=0x50 reg=0x10 data=0xA5, master acks all -> cmd_op/data seq START, WRITE 0xA0,
//   WRITE 0x10, WRITE 0xA5, STOP; resp_valid 1 cycle, nack=0, timeout=0, rdata=0.
//  Read dev=0x50 reg=0x22, done_data=0x5C -> START, 0xA0, 0x22, RESTART, WRITE 0xA1, READ_NACK, STOP;
//   resp_rdata=0x5C.
//  Write with done_ack=0 on dev byte -> next cmd STOP, no reg byte; resp_nack=1, rdata=0.
//  TIMEOUT_CYCLES=8, master never pulses done after START -> STOP issued after 8 WAIT cycles;
//   resp_timeout=1.
//  cmd_ready held low 20 cycles -> cmd_valid/op/data stable, timer stays 0, no resp_valid.
//  reset_n low during WDATA wait -> next cycle IDLE, req_ready=1, cmd_valid=0, no resp_valid.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_sequencer
//  Purpose  : Turns single register read/write requests into the sequence of
//             byte-level commands for an I2C master and reports the outcome.
//               write: START, dev+W, reg, data, STOP
//               read : START, dev+W, reg, RESTART, dev+R, READ_NACK, STOP
//             A slave NACK or a master that stays silent too long aborts the
//             sequence. Every started transaction ends with STOP.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset_n          clock, synchronous active-low reset
//    req_valid/req_ready   client request handshake
//    req_rw                1 = read, 0 = write
//    req_dev_addr[6:0]     slave address
//    req_reg_addr[7:0]     register address
//    req_wdata[7:0]        write data
//    resp_valid            one-cycle completion pulse
//    resp_rdata[7:0]       read data (0 on writes and aborts)
//    resp_nack             slave NACKed an address/data byte
//    resp_timeout          master did not report done in time
//    cmd_valid/cmd_ready   command handshake towards the master
//    cmd_op[2:0]           0 START 1 RESTART 2 WRITE 3 READ_ACK 4 READ_NACK 5 STOP
//    cmd_data[7:0]         byte for WRITE, 0 otherwise
//    done_valid            master completion pulse
//    done_ack              slave ACK after a WRITE
//    done_data[7:0]        received byte after a READ
// ============================================================================
module i2c_reg_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_nack,
  output logic       resp_timeout,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_data,
  input  logic       done_valid,
  input  logic       done_ack,
  input  logic [7:0] done_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_REG, S_WDATA,
    S_RESTART, S_DEV_R, S_READ, S_STOP, S_RESP
  } state_t;

  localparam logic [2:0] c_OP_START     = 3'd0;
  localparam logic [2:0] c_OP_RESTART   = 3'd1;
  localparam logic [2:0] c_OP_WRITE     = 3'd2;
  localparam logic [2:0] c_OP_READ_NACK = 3'd4;
  localparam logic [2:0] c_OP_STOP      = 3'd5;

  state_t      state_q, state_d;
  logic        issue_q, issue_d;   // 1 = ISSUE phase, 0 = WAIT phase
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        nack_q, nack_d;
  logic        timeout_q, timeout_d;
  logic [15:0] timer_q, timer_d;

  logic        w_cmd_state;
  logic        w_ack_checked;
  logic [15:0] w_timer_inc;
  logic [2:0]  w_op;
  logic [7:0]  w_byte;

  assign w_cmd_state   = (state_q != S_IDLE) && (state_q != S_RESP);
  // Only address/data bytes carry a meaningful ACK from the slave.
  assign w_ack_checked = (state_q == S_DEV_W) || (state_q == S_REG) ||
                         (state_q == S_WDATA) || (state_q == S_DEV_R);
  assign w_timer_inc   = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  always_comb begin
    w_op   = c_OP_START;
    w_byte = 8'h00;
    case (state_q)
      S_DEV_W:   begin w_op = c_OP_WRITE; w_byte = {dev_q, 1'b0}; end
      S_REG:     begin w_op = c_OP_WRITE; w_byte = reg_q;         end
      S_WDATA:   begin w_op = c_OP_WRITE; w_byte = wdata_q;       end
      S_RESTART: w_op = c_OP_RESTART;
      S_DEV_R:   begin w_op = c_OP_WRITE; w_byte = {dev_q, 1'b1}; end
      S_READ:    w_op = c_OP_READ_NACK;
      S_STOP:    w_op = c_OP_STOP;
      default:   w_op = c_OP_START;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign cmd_valid    = w_cmd_state && issue_q;
  assign cmd_op       = cmd_valid ? w_op : 3'd0;
  assign cmd_data     = cmd_valid ? w_byte : 8'h00;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_nack    = resp_valid && nack_q;
  assign resp_timeout = resp_valid && timeout_q;
  assign resp_rdata   = (resp_valid && !nack_q && !timeout_q) ? rdata_q : 8'h00;

  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    timer_d   = timer_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d      = req_rw;
          dev_d     = req_dev_addr;
          reg_d     = req_reg_addr;
          wdata_d   = req_wdata;
          rdata_d   = 8'h00;
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          timer_d   = 16'd0;
          issue_d   = 1'b1;
          state_d   = S_START;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        if (issue_q) begin
          if (cmd_ready) begin
            issue_d = 1'b0;
            timer_d = 16'd0;
          end
        end else if (done_valid) begin
          // A completion in the same cycle as the timeout limit wins.
          issue_d = 1'b1;
          if (w_ack_checked && !done_ack) begin
            nack_d = 1'b1;
          end
          case (state_q)
            S_START:   state_d = S_DEV_W;
            S_DEV_W:   state_d = done_ack ? S_REG : S_STOP;
            S_REG:     state_d = !done_ack ? S_STOP : (rw_q ? S_RESTART : S_WDATA);
            S_WDATA:   state_d = S_STOP;
            S_RESTART: state_d = S_DEV_R;
            S_DEV_R:   state_d = done_ack ? S_READ : S_STOP;
            S_READ: begin
              rdata_d = done_data;
              state_d = S_STOP;
            end
            S_STOP:    state_d = S_RESP;
            default:   state_d = S_IDLE;
          endcase
        end else begin
          // The counted value reaching the limit means this is the last
          // WAIT cycle the master was allowed.
          timer_d = w_timer_inc;
          if (w_timer_inc == TIMEOUT_CYCLES) begin
            timeout_d = 1'b1;
            issue_d   = 1'b1;
            state_d   = (state_q == S_STOP) ? S_RESP : S_STOP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      issue_q   <= 1'b0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
    end
  end

endmodule
`default_nettype wire
